// File: rtl/dmem_access_ctrl.sv
// Purpose: multi-cycle data-memory access controller between the MEM stage and a slow req/ack data bus.
// Latency: IDLE + k REQ cycles (ack in k-th) + 1 DONE cycle; misaligned accesses take IDLE + DONE.
// Backpressure: mem_stall freezes the pipeline from request acceptance until the DONE cycle.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        err_clr,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last REQ cycle index before the access is abandoned.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             act;
  logic             aligned;

  // A store wins over a load when both are asserted, so any qualified op is an access.
  assign act     = mem_valid & (mem_ren | mem_wen);
  assign aligned = (mem_addr[1:0] == 2'b00);
  assign mem_din = rdata_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and stall; stall is gated by reset so it drops as soon as reset asserts.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        mem_stall = act;
        if (act) begin
          state_d = aligned ? REQ : DONE;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (bus_ack || (cnt == TMO_LAST)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!rst_n) begin
      mem_stall = 1'b0;
    end
  end

  // Bus command, timeout counter, read-data capture and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      rdata_q      <= '0;
      cnt          <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_misalign <= 1'b0;
      // Clear first so a timeout detected in the same cycle overrides it.
      if (err_clr) begin
        err_timeout <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (act) begin
            if (aligned) begin
              bus_req   <= 1'b1;
              bus_we    <= mem_wen;
              bus_addr  <= mem_addr[31:2];
              bus_wdata <= mem_dout;
              cnt       <= '0;
            end else begin
              err_misalign <= 1'b1;
              rdata_q      <= '0;
            end
          end
        end
        REQ: begin
          // An ack on the expiry cycle is still a success.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) begin
              rdata_q <= bus_rdata;
            end
          end else if (cnt == TMO_LAST) begin
            bus_req     <= 1'b0;
            rdata_q     <= '0;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err_clr;
  logic        err_misalign;
  logic        err_timeout;

  int n_cmp;
  int n_bad;

  dmem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .mem_ren      (mem_ren),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din),
    .mem_stall    (mem_stall),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .err_clr      (err_clr),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance past the next rising edge; registered outputs are then stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 32'h0;
    mem_dout  = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    err_clr   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #23;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    n_cmp++; if (mem_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
    n_cmp++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL reset_din got=%h exp=0", mem_din); end
    n_cmp++; if ({bus_we, bus_addr, bus_wdata} !== 63'h0) begin n_bad++; $display("FAIL reset_bus got=%b/%h/%h exp=0", bus_we, bus_addr, bus_wdata); end
    n_cmp++; if ({err_misalign, err_timeout} !== 2'b00) begin n_bad++; $display("FAIL reset_err got=%b%b exp=00", err_misalign, err_timeout); end
    rst_n = 1'b1;
    tick();
    // Stray ack while idle must be ignored.
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (mem_din !== 32'h0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL idle_ack din=%h req=%b exp din=0 req=0", mem_din, bus_req); end
  endtask

  task automatic test_load();
    mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h0000_0010;
    #1;
    n_cmp++; if (mem_stall !== 1'b1 || bus_req !== 1'b0) begin n_bad++; $display("FAIL load_idle stall=%b req=%b exp 1/0", mem_stall, bus_req); end
    tick();
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 30'h4 || bus_we !== 1'b0 || mem_stall !== 1'b1) begin n_bad++; $display("FAIL load_req1 req=%b addr=%h we=%b stall=%b exp 1/4/0/1", bus_req, bus_addr, bus_we, mem_stall); end
    tick();
    n_cmp++; if (bus_req !== 1'b1 || mem_stall !== 1'b1) begin n_bad++; $display("FAIL load_req2 req=%b stall=%b exp 1/1", bus_req, mem_stall); end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL load_done stall=%b req=%b exp 0/0", mem_stall, bus_req); end
    n_cmp++; if (mem_din !== 32'h1234_5678) begin n_bad++; $display("FAIL load_data got=%h exp=12345678", mem_din); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL load_idle_after stall=%b req=%b exp 0/0", mem_stall, bus_req); end
  endtask

  task automatic test_store();
    mem_valid = 1'b1; mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'hCAFE_F00D;
    #1;
    n_cmp++; if (mem_stall !== 1'b1) begin n_bad++; $display("FAIL store_idle_stall got=%b exp=1", mem_stall); end
    tick();
    n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 30'h8 || bus_wdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL store_req req=%b we=%b addr=%h wd=%h exp 1/1/8/cafef00d", bus_req, bus_we, bus_addr, bus_wdata); end
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (mem_stall !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL store_done stall=%b req=%b exp 0/0", mem_stall, bus_req); end
    n_cmp++; if (mem_din !== 32'h1234_5678) begin n_bad++; $display("FAIL store_din got=%h exp=12345678", mem_din); end
    tick();
    idle_inputs();
  endtask

  task automatic test_misalign();
    mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h13;
    #1;
    n_cmp++; if (mem_stall !== 1'b1 || err_misalign !== 1'b0) begin n_bad++; $display("FAIL mis_idle stall=%b mis=%b exp 1/0", mem_stall, err_misalign); end
    tick();
    n_cmp++; if (err_misalign !== 1'b1 || bus_req !== 1'b0 || mem_stall !== 1'b0) begin n_bad++; $display("FAIL mis_done mis=%b req=%b stall=%b exp 1/0/0", err_misalign, bus_req, mem_stall); end
    n_cmp++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL mis_din got=%h exp=0", mem_din); end
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (err_misalign !== 1'b0 || bus_req !== 1'b0) begin n_bad++; $display("FAIL mis_after mis=%b req=%b exp 0/0", err_misalign, bus_req); end
  endtask

  task automatic test_timeout();
    mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus_req !== 1'b1 || mem_stall !== 1'b1) begin n_bad++; $display("FAIL tmo_req%0d req=%b stall=%b exp 1/1", i, bus_req, mem_stall); end
    end
    tick();
    n_cmp++; if (bus_req !== 1'b0 || err_timeout !== 1'b1 || mem_stall !== 1'b0) begin n_bad++; $display("FAIL tmo_done req=%b tmo=%b stall=%b exp 0/1/0", bus_req, err_timeout, mem_stall); end
    n_cmp++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL tmo_din got=%h exp=0", mem_din); end
    tick();
    idle_inputs();
    tick();
    n_cmp++; if (err_timeout !== 1'b1) begin n_bad++; $display("FAIL tmo_sticky got=%b exp=1", err_timeout); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (err_timeout !== 1'b0) begin n_bad++; $display("FAIL tmo_clear got=%b exp=0", err_timeout); end
  endtask

  task automatic test_ack_at_expiry();
    mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h34;
    tick();
    tick();
    tick();
    tick();
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL edge_req4 got=%b exp=1", bus_req); end
    bus_ack = 1'b1; bus_rdata = 32'hA5A5_A5A5;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (err_timeout !== 1'b0 || mem_din !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL edge_done tmo=%b din=%h exp 0/a5a5a5a5", err_timeout, mem_din); end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    mem_valid = 1'b1; mem_ren = 1'b1; mem_addr = 32'h50;
    tick();
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req got=%b exp=1", bus_req); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_req !== 1'b0 || mem_stall !== 1'b0) begin n_bad++; $display("FAIL rst_mid req=%b stall=%b exp 0/0", bus_req, mem_stall); end
    n_cmp++; if (mem_din !== 32'h0) begin n_bad++; $display("FAIL rst_din got=%h exp=0", mem_din); end
    tick();
    rst_n = 1'b1;
    mem_ren = 1'b1; mem_wen = 1'b1; mem_addr = 32'h40; mem_dout = 32'h1111_2222;
    #1;
    n_cmp++; if (mem_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_stall got=%b exp=1", mem_stall); end
    tick();
    n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 30'h10 || bus_wdata !== 32'h1111_2222) begin n_bad++; $display("FAIL b2b_wr req=%b we=%b addr=%h wd=%h exp 1/1/10/11112222", bus_req, bus_we, bus_addr, bus_wdata); end
    bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (mem_stall !== 1'b0 || mem_din !== 32'h0) begin n_bad++; $display("FAIL b2b_wr_done stall=%b din=%h exp 0/0", mem_stall, mem_din); end
    tick();
    mem_wen = 1'b0; mem_ren = 1'b1; mem_addr = 32'h44;
    #1;
    n_cmp++; if (mem_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_rd_idle got=%b exp=1", mem_stall); end
    tick();
    n_cmp++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 30'h11) begin n_bad++; $display("FAIL b2b_rd_req req=%b we=%b addr=%h exp 1/0/11", bus_req, bus_we, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if (mem_din !== 32'h0BAD_F00D || mem_stall !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_done din=%h stall=%b exp 0badf00d/0", mem_din, mem_stall); end
    tick();
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_ack_at_expiry();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Multi-cycle data-memory access controller directly downstream of the datapath MEM stage.
- Consumes mem_ren/mem_wen/mem_addr/mem_dout, runs a req/ack transaction on a slow data bus, and returns mem_din to the pipeline.
- Asserts mem_stall so the hazard controller freezes the pipeline until the access completes.
- Also detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: max REQ-state cycles without bus_ack before abort; legal range 1..2^CNT_W-1.
- CNT_W, 8: timeout counter width.

Ports:
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_ren  in  1  load request from MEM stage.
- mem_wen  in  1  store request from MEM stage.
- mem_addr  in  32  byte address, ALU result.
- mem_dout  in  32  store data.
- mem_din  out  32  load data to MEM/WB.
- mem_stall  out  1  freeze pipeline while high.
- bus_req  out  1  bus request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  30  word address = mem_addr[31:2], registered.
- bus_wdata  out  32  write data, registered.
- bus_ack  in  1  one-cycle completion pulse from bus.
- bus_rdata  in  32  read data, valid with bus_ack.
- err_clr  in  1  clears err_timeout.
- err_misalign  out  1  one-cycle pulse, misaligned access dropped.
- err_timeout  out  1  sticky, access aborted by timeout.

Behaviour:
- Reset (async, rst_n low): state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0.
  - rdata_q=0, mem_din=0, cnt=0, err_misalign=0, err_timeout=0.
  - mem_stall=0.
- Request qualifier: act = mem_valid & (mem_ren | mem_wen).
  - If both ren and wen are high, the write wins and the read is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - mem_stall = act (combinational, same cycle).
  - act & mem_addr[1:0]==0:
    - latch bus_addr/bus_wdata/bus_we.
    - bus_req<=1, cnt<=0, next REQ.
  - act & mem_addr[1:0]!=0:
    - no bus access; err_misalign<=1 for one cycle.
    - rdata_q<=0, next DONE.
  - Otherwise stay in IDLE.
- REQ:
  - mem_stall=1; bus_req, bus_addr, bus_we and bus_wdata are held stable.
  - bus_ack: bus_req<=0; if read, rdata_q<=bus_rdata; next DONE.
  - No ack and cnt==TIMEOUT-1: bus_req<=0, rdata_q<=0, err_timeout<=1, next DONE.
  - Otherwise cnt<=cnt+1.
  - Inputs mem_* are ignored in REQ; the pipeline holds them under stall.
- DONE:
  - mem_stall=0; lasts exactly one cycle, so the pipeline advances on this edge.
  - Inputs are ignored (the same request is still present); next IDLE.
- mem_din = rdata_q in all states.
  - It therefore equals load data in the DONE cycle, when the WB register captures it.
  - Writes leave rdata_q unchanged.
- Latency: ack in the k-th REQ cycle (k>=1) gives total stall k+1 cycles, then 1 DONE cycle.
  - Minimum access is 3 cycles: IDLE, REQ, DONE.
- bus_ack outside REQ is ignored.
- err_timeout clears on err_clr.
  - If err_clr and a new timeout occur in the same cycle, set wins.
- An ack in the same cycle as timeout expiry counts as success: no error, data captured.
- Reset mid-REQ aborts immediately: bus_req drops asynchronously, no DONE.
- Back-to-back accesses: a new request is accepted in the IDLE cycle right after DONE, with no extra bubble.

Test Plan:
1. Load hit: mem_valid=1, mem_ren=1, addr=0x0000_0010; bus_ack 2 cycles after bus_req with rdata=0x1234_5678.
   -> bus_addr=0x4, bus_we=0; mem_stall high for 3 cycles, then DONE with mem_din=0x1234_5678.
2. Store: wen=1, addr=0x20, dout=0xCAFE_F00D; ack in first REQ cycle.
   -> bus_we=1, bus_wdata=0xCAFE_F00D, bus_addr=0x8; stall 2 cycles; mem_din unchanged.
3. Misaligned load, addr=0x13.
   -> no bus_req; err_misalign pulses 1 cycle; mem_stall high 1 cycle; DONE with mem_din=0.
4. Timeout: TIMEOUT=4, no ack.
   -> bus_req high exactly 4 cycles then drops; err_timeout=1 and stays high until err_clr; mem_din=0.
5. Ack on the last timeout cycle (cycle 4 with TIMEOUT=4), rdata=0xA5A5_A5A5.
   -> err_timeout stays 0; mem_din=0xA5A5_A5A5.
6. rst_n low during REQ.
   -> bus_req=0, mem_stall=0 immediately.
   After release: ren+wen both high at addr=0x40 -> write issued (bus_we=1).
   Then back-to-back load issued the cycle after DONE.
